// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master arbiter in front of the shared data-memory/GPIO space
//   (RAM below 0x80, DDR 0x80, PORT 0x81, PIN 0x82). Master 0 is the CPU,
//   master 1 a DMA/debug port. One transfer is granted per arbitration
//   cycle (round-robin on ties), optionally locked to the current owner for
//   short bursts, and completed with a one-cycle ack carrying registered
//   read data.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   mX_req/we/lock         master X request, write enable, burst lock
//   mX_addr/wd             master X address and write data
//   mX_ack                 one-cycle completion pulse to master X
//   mX_rd                  master X read data, valid while mX_ack=1, else 0
//   mem_we/addr/wd         memory bus driven in the arbitration cycle
//   mem_rd                 combinational memory read of mem_addr
module mem_bus_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic             m0_lock,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wd,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rd,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic             m1_lock,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wd,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rd,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } state_t;

  state_t          state;
  logic            owner;
  logic            rr_last;
  logic            lock_pend;   // owner's lock as sampled in the last ACK
  logic [CW-1:0]   lock_cnt;    // locked grants taken in the current burst
  logic [WIDTH-1:0] rd_q;

  logic             any_req;
  logic             own_req;
  logic             owner_lock;
  logic             lock_ok;
  logic             grant;
  logic             win;
  logic             win_we;
  logic [WIDTH-1:0] win_addr;
  logic [WIDTH-1:0] win_wd;

  assign any_req    = m0_req | m1_req;
  assign own_req    = owner ? m1_req  : m0_req;
  assign owner_lock = owner ? m1_lock : m0_lock;

  // A locked owner keeps the bus only while it is still requesting and has
  // not yet used up its burst allowance.
  assign lock_ok = lock_pend && own_req && (lock_cnt < CW'(BURST_MAX));

  always_comb begin
    win = 1'b0;
    if (lock_ok)
      win = owner;
    else if (m0_req && !m1_req)
      win = 1'b0;
    else if (m1_req && !m0_req)
      win = 1'b1;
    else
      win = ~rr_last;
  end

  assign win_we   = win ? m1_we   : m0_we;
  assign win_addr = win ? m1_addr : m0_addr;
  assign win_wd   = win ? m1_wd   : m0_wd;

  // The bus is combinational in ARB; rst gates it so nothing reaches the
  // memory while reset is held with requests pending.
  assign grant    = rst && (state == ARB) && any_req;
  assign mem_we   = grant && win_we;
  assign mem_addr = grant ? win_addr : '0;
  assign mem_wd   = grant ? win_wd   : '0;

  assign m0_rd = m0_ack ? rd_q : '0;
  assign m1_rd = m1_ack ? rd_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      lock_pend <= 1'b0;
      lock_cnt  <= '0;
      rd_q      <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (any_req) begin
            rd_q    <= mem_rd;
            owner   <= win;
            rr_last <= win;
            m0_ack  <= ~win;
            m1_ack  <= win;
            state   <= ACK;
            // Counting locked grants here (rather than lock samples) makes
            // the cap mean "initial grant plus BURST_MAX locked grants".
            // At the cap with the other master idle the count is held.
            if (lock_ok)
              lock_cnt <= lock_cnt + 1'b1;
            else if (!(lock_pend && own_req && (win == owner)))
              lock_cnt <= '0;
          end else begin
            // Owner dropped its request: the lock is released.
            lock_pend <= 1'b0;
            lock_cnt  <= '0;
          end
        end
        ACK: begin
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          lock_pend <= owner_lock;
          if (!owner_lock)
            lock_cnt <= '0;
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with a small RAM/GPIO memory model.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wd, m0_rd;
  logic        m0_ack;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wd, m1_rd;
  logic        m1_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // memory model: RAM below 0x80, DDR/PORT registers, PIN reads back driven port bits
  logic [31:0] ram [0:127];
  logic [31:0] ddr, port;

  mem_bus_arbiter #(.WIDTH(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32'h80)       ram[mem_addr[6:0]] <= mem_wd;
      else if (mem_addr == 32'h80) ddr  <= mem_wd;
      else if (mem_addr == 32'h81) port <= mem_wd;
    end
  end

  always_comb begin
    mem_rd = '0;
    if (mem_addr < 32'h80)       mem_rd = ram[mem_addr[6:0]];
    else if (mem_addr == 32'h80) mem_rd = ddr;
    else if (mem_addr == 32'h81) mem_rd = port;
    else if (mem_addr == 32'h82) mem_rd = ddr & port;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wd = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wd = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = '0;
    ram[16] = 32'hDEADBEEF;
    ddr  = '0;
    port = '0;
    rst  = 1'b0;
    set_m0(1'b1, 1'b1, 1'b0, 32'h20, 32'h11112222);
    set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);

    // reset held with both masters requesting
    #2;
    check_eq("rst_m0_ack", {31'b0, m0_ack}, 32'h0);
    check_eq("rst_m1_ack", {31'b0, m1_ack}, 32'h0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check_eq("rst_m0_rd",  m0_rd, 32'h0);
    check_eq("rst_m1_rd",  m1_rd, 32'h0);
    tick;
    tick;
    check_eq("rst_hold_m0_ack", {31'b0, m0_ack}, 32'h0);
    check_eq("rst_hold_mem_we", {31'b0, mem_we}, 32'h0);

    // release: m0 wins the first tie and its write goes out combinationally
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("first_mem_we",   {31'b0, mem_we}, 32'h1);
    check_eq("first_mem_addr", mem_addr, 32'h20);
    check_eq("first_mem_wd",   mem_wd, 32'h11112222);
    tick;
    check_eq("first_m0_ack", {31'b0, m0_ack}, 32'h1);
    check_eq("first_m1_ack", {31'b0, m1_ack}, 32'h0);
    check_eq("ack_bus_idle", {31'b0, mem_we}, 32'h0);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // single read by m1 of 0x10
    tick;
    check_eq("rd_mem_addr", mem_addr, 32'h10);
    check_eq("rd_mem_we",   {31'b0, mem_we}, 32'h0);
    tick;
    check_eq("rd_m1_ack", {31'b0, m1_ack}, 32'h1);
    check_eq("rd_m1_rd",  m1_rd, 32'hDEADBEEF);
    check_eq("rd_m0_ack", {31'b0, m0_ack}, 32'h0);
    check_eq("rd_m0_rd",  m0_rd, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    check_eq("idle_acks",     {30'b0, m1_ack, m0_ack}, 32'h0);
    check_eq("idle_mem_addr", mem_addr, 32'h0);
    check_eq("write_landed",  ram[32], 32'h11112222);

    // round-robin: continuous requests alternate m0, m1, m0, m1
    set_m0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq($sformatf("rr_acks_%0d", i), {30'b0, m1_ack, m0_ack},
               (i % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("rr_rd_%0d", i), (i % 2 == 0) ? m0_rd : m1_rd,
               (i % 2 == 0) ? 32'h11112222 : 32'hDEADBEEF);
      tick;
    end
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // burst cap: m0 locked with m1 waiting -> five m0 acks, then m1
    set_m0(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check_eq($sformatf("burst_acks_%0d", i), {30'b0, m1_ack, m0_ack},
               (i == 5) ? 32'h2 : 32'h1);
      tick;
    end
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // saturated lock with m1 idle: m0 keeps winning; m1 raised during an ACK then wins
    set_m0(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check_eq($sformatf("sat_acks_%0d", i), {30'b0, m1_ack, m0_ack}, 32'h1);
      if (i == 5) set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      tick;
    end
    tick;
    check_eq("sat_switch_acks", {30'b0, m1_ack, m0_ack}, 32'h2);
    check_eq("sat_switch_rd",   m1_rd, 32'hDEADBEEF);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // GPIO: DDR=0xFF, PORT=0xA5, then m1 reads PIN
    set_m0(1'b1, 1'b1, 1'b0, 32'h80, 32'hFF);
    tick;
    check_eq("gpio_ddr_ack", {31'b0, m0_ack}, 32'h1);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    set_m0(1'b1, 1'b1, 1'b0, 32'h81, 32'hA5);
    tick;
    check_eq("gpio_port_ack", {31'b0, m0_ack}, 32'h1);
    check_eq("gpio_ddr",      ddr, 32'hFF);
    check_eq("gpio_port",     port, 32'hA5);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    set_m1(1'b1, 1'b0, 1'b0, 32'h82, 32'h0);
    #1;
    check_eq("gpio_pin_addr", mem_addr, 32'h82);
    tick;
    check_eq("gpio_pin_ack", {31'b0, m1_ack}, 32'h1);
    check_eq("gpio_pin_rd",  m1_rd, 32'hA5);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // reset during the ACK of an m1 read
    set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    tick;
    check_eq("midrst_pre_ack", {31'b0, m1_ack}, 32'h1);
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check_eq("midrst_m1_ack", {31'b0, m1_ack}, 32'h0);
    check_eq("midrst_m1_rd",  m1_rd, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    check_eq("midrst_first_acks", {30'b0, m1_ack, m0_ack}, 32'h1);
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
